// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store stage: FSM states,
// RV32I funct3 width codes, exception cause codes and request checks.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_ILLEGAL    = 2'd2,
        CAUSE_TIMEOUT    = 2'd3
    } cause_t;

    // Load width codes
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Access size lives in funct3[1:0] for every legal load and store
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Op type must be exactly one of load/store, and funct3 must be a defined width
    function automatic logic is_illegal(logic ld, logic st, logic [2:0] f3);
        if (ld == st) return 1'b1;
        if (ld) return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return (f3 >= 3'd3);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address
    function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] offset);
        case (f3[1:0])
            SIZE_HALF: return offset[0];
            SIZE_WORD: return (offset != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store data replication and byte enables,
// load byte/halfword extraction with sign or zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_byte,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Replicate the store operand across all lanes and enable only the addressed ones
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        st_data = st_wdata;
        st_byte = 4'b1111;
        case (st_funct3[1:0])
            SIZE_BYTE: begin
                st_data = {4{st_wdata[7:0]}};
                st_byte = 4'b0001 << st_offset;
            end
            SIZE_HALF: begin
                st_data = {2{st_wdata[15:0]}};
                st_byte = 4'b0011 << st_offset;
            end
            default: ;
        endcase
    end

    // Move the addressed byte/halfword down to bit 0, then extend per funct3[2]
    always_comb begin
        shifted = ld_rdata >> {ld_offset, 3'b000};
        ld_data = shifted;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  ld_data = {24'd0, shifted[7:0]};
            F3_LHU:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: one outstanding data-memory request, request checking,
// bus-timeout watchdog and fully registered outputs toward memory and writeback.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        dmem_read_ready,
    output logic [31:0] dmem_read_address,
    input  logic        dmem_read_valid,
    input  logic [31:0] dmem_read_data,
    output logic        dmem_write_ready,
    output logic [31:0] dmem_write_address,
    output logic [31:0] dmem_write_data,
    output logic [3:0]  dmem_write_byte,
    input  logic        dmem_write_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        exception,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam int              CNT_W    = 10;
    // The wait that would bring the count to TIMEOUT is the last one allowed
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q;
    logic [2:0]         funct3_q;
    logic [4:0]         rd_q;

    logic               accept_load, accept_store;
    logic               wb_fire, st_fire, exc_fire;
    cause_t             exc_cause_d;
    logic [31:0]        exc_addr_d;

    logic [31:0]        st_data, ld_data;
    logic [3:0]         st_byte;

    mem_align u_align (
        .st_funct3 (ex_funct3),
        .st_offset (ex_addr[1:0]),
        .st_wdata  (ex_wdata),
        .st_data   (st_data),
        .st_byte   (st_byte),
        .ld_funct3 (funct3_q),
        .ld_offset (addr_q[1:0]),
        .ld_rdata  (dmem_read_data),
        .ld_data   (ld_data)
    );

    // Next-state, watchdog and event decode; acknowledges only count in their own state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_load  = 1'b0;
        accept_store = 1'b0;
        wb_fire      = 1'b0;
        st_fire      = 1'b0;
        exc_fire     = 1'b0;
        exc_cause_d  = CAUSE_NONE;
        exc_addr_d   = ex_addr;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_illegal(ex_load, ex_store, ex_funct3)) begin
                        exc_fire    = 1'b1;
                        exc_cause_d = CAUSE_ILLEGAL;
                    end else if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
                        exc_fire    = 1'b1;
                        exc_cause_d = CAUSE_MISALIGNED;
                    end else if (ex_load) begin
                        accept_load = 1'b1;
                        state_d     = ST_READ;
                        cnt_d       = '0;
                    end else begin
                        accept_store = 1'b1;
                        state_d      = ST_WRITE;
                        cnt_d        = '0;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                if ((state_q == ST_READ) ? dmem_read_valid : dmem_write_valid) begin
                    wb_fire = (state_q == ST_READ);
                    st_fire = (state_q == ST_WRITE);
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    exc_fire    = 1'b1;
                    exc_cause_d = CAUSE_TIMEOUT;
                    exc_addr_d  = addr_q;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and watchdog counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the accepted request fields needed while the access is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
        end else if (accept_load || accept_store) begin
            addr_q   <= ex_addr;
            funct3_q <= ex_funct3;
            rd_q     <= ex_rd;
        end
    end

    // Registered outputs, so nothing downstream sees a combinational path from the acknowledges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ready           <= 1'b1;
            dmem_read_ready    <= 1'b0;
            dmem_read_address  <= '0;
            dmem_write_ready   <= 1'b0;
            dmem_write_address <= '0;
            dmem_write_data    <= '0;
            dmem_write_byte    <= '0;
            wb_valid           <= 1'b0;
            wb_rd              <= '0;
            wb_data            <= '0;
            st_done            <= 1'b0;
            exception          <= 1'b0;
            exc_cause          <= '0;
            exc_addr           <= '0;
        end else begin
            ex_ready         <= (state_d == ST_IDLE);
            dmem_read_ready  <= (state_d == ST_READ);
            dmem_write_ready <= (state_d == ST_WRITE);
            wb_valid         <= wb_fire;
            st_done          <= st_fire;
            exception        <= exc_fire;
            if (accept_load) begin
                dmem_read_address <= {ex_addr[31:2], 2'b00};
            end
            if (accept_store) begin
                dmem_write_address <= {ex_addr[31:2], 2'b00};
                dmem_write_data    <= st_data;
                dmem_write_byte    <= st_byte;
            end
            if (wb_fire) begin
                wb_data <= ld_data;
                wb_rd   <= rd_q;
            end
            if (exc_fire) begin
                exc_cause <= exc_cause_d;
                exc_addr  <= exc_addr_d;
            end
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store stage of the 3-stage RISC-V core: accepts one memory request from `execute`, drives the data-memory request/acknowledge handshake, and hands a formatted load result to `wb`. Performs byte-lane steering for stores, sign/zero extension for loads, misalignment detection and a bus-timeout watchdog. It holds at most one outstanding request.

## Interface
- `TIMEOUT`, 255: max cycles waiting for a memory acknowledge before a bus error (1..1023).
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents a memory op.
- `ex_ready`  out  1  block can accept (high only in IDLE).
- `ex_load` / `ex_store`  in  1 each  op type.
- `ex_funct3`  in  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `ex_addr`  in  32  effective address.
- `ex_wdata`  in  32  rs2 store data.
- `ex_rd`  in  5  load destination register.
- `dmem_read_ready`  out  1  read request.
- `dmem_read_address`  out  32  word-aligned read address.
- `dmem_read_valid`  in  1  read data valid / acknowledge.
- `dmem_read_data`  in  32  read word.
- `dmem_write_ready`  out  1  write request.
- `dmem_write_address`  out  32  word-aligned write address.
- `dmem_write_data`  out  32  lane-steered store data.
- `dmem_write_byte`  out  4  byte enables.
- `dmem_write_valid`  in  1  write acknowledge.
- `wb_valid`  out  1  one-cycle pulse: load result ready.
- `wb_rd`  out  5, `wb_data`  out  32  load destination and extended value.
- `st_done`  out  1  one-cycle pulse: store acknowledged.
- `exception`  out  1  one-cycle pulse: misaligned, illegal or timeout.
- `exc_cause`  out  2  1=misaligned, 2=illegal, 3=bus timeout.
- `exc_addr`  out  32  faulting `ex_addr`.

## Operation
- States: IDLE, READ, WRITE.
- IDLE: `ex_ready`=1. On `ex_valid`, check the request, then either raise an error or latch `addr`, `funct3`, `wdata`, `rd` and move to the memory state.
  - Illegal: `ex_load`=`ex_store`, load funct3 in {3,6,7}, or store funct3 ≥3. Raise `exception` with cause 2 and stay in IDLE.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Raise `exception` with cause 1 and stay in IDLE.
  - Valid load goes to READ; valid store goes to WRITE.
- READ: `dmem_read_ready`=1 and `dmem_read_address`={addr[31:2],2'b00} are held until `dmem_read_valid`.
  - Extract the byte/halfword selected by addr[1:0] and sign- or zero-extend it.
  - Register `wb_data` and `wb_rd`, pulse `wb_valid`, return to IDLE.
- WRITE: `dmem_write_ready`=1, with address, data and byte enables held until `dmem_write_valid`. Then pulse `st_done` and return to IDLE.
  - Byte enables: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111.
  - Data: the byte/halfword is replicated across lanes.
- Watchdog counter: cleared on entry to READ/WRITE, incremented each waiting cycle. When it reaches `TIMEOUT` with no acknowledge:
  - pulse `exception` with cause 3, `exc_addr`=latched addr;
  - drop the request and return to IDLE;
  - discard any later stray acknowledge.
- Acknowledges (`dmem_read_valid`, `dmem_write_valid`) are ignored in IDLE and in the other memory state.
- Request outputs are 0 outside their state; address/data outputs are don't-care when their request is low.

## Timing
- Reset (async, active-low): state=IDLE, counter=0. All outputs are 0 except `ex_ready`=1. Reset mid-transaction abandons the request with no pulse.
- Request accepted at edge T; `dmem_*_ready` is high from T+1.
- An acknowledge sampled at edge T+1+k makes `wb_valid`/`st_done` high for cycle T+1+k. Best-case load latency is 2 edges from acceptance.
- `ex_ready` rises in the same cycle as `wb_valid`/`st_done`, allowing back-to-back requests (one per 2 cycles minimum).
- `exception` for misaligned/illegal is registered: it is high in the cycle after acceptance, and `ex_ready` stays high.
- An acknowledge arriving on the same edge the counter hits `TIMEOUT` wins: completion, no exception.
- All outputs are registered; no combinational path from `dmem_*_valid` to any output.

## Structure
- Package `mem_access_pkg` holds:
  - the state enum;
  - funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2);
  - cause codes.
- Sub-module `mem_align` (combinational) contains store lane steering/byte enables and load extraction/extension; it is instantiated once.

## Test plan
- LW 0x100, memory returns 0xDEADBEEF on the first request cycle -> `wb_valid` 2 cycles after acceptance, `wb_data`=0xDEADBEEF, `wb_rd` echoed.
- LB addr 0x103, read data 0x80123456 -> `wb_data`=0xFFFFFF80. LBU same -> 0x00000080. LHU 0x102 -> 0x00008012.
- SB addr 0x0000_0006, wdata 0x000000A5 -> `dmem_write_byte`=4'b0100, `dmem_write_data`=0xA5A5A5A5, address 0x4. Ack after 3 wait cycles -> `st_done` pulse, no `wb_valid`.
- LW 0x102 -> `exception`, cause 1, `exc_addr`=0x102, no `dmem_read_ready`. funct3=7 load -> cause 2.
- `TIMEOUT`=4, load never acknowledged -> `exception` cause 3 after 4 waiting cycles, back to IDLE; a late ack is ignored.
- Assert `reset` low while in WRITE -> `dmem_write_ready` drops immediately; after release, `ex_ready`=1 and no pulses.
